one_hot_stream_encoder: RTL and testbench
=========================================

// Module: one_hot_stream_encoder
// PURPOSE
//  Streaming one-hot -> binary encoder with valid/ready handshakes on both sides.
//  It is the return path for one_hot_decoder outputs in datapaths that need flow control.
//  It validates each word: zero or multi-hot input is flagged per word and counted in a
//  saturating error counter. Sits between a one-hot producer (arbiter/decoder) and a
//  binary-index consumer.
// PARAMETERS
//  N          8           one-hot input width (N >= 2)
//  IDX_W      $clog2(N)   binary index width
//  ERR_CNT_W  8           width of the saturating error counter
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          in_onehot is valid this cycle
//  in_ready   out  1          block can accept a word this cycle
//  in_onehot  in   N          one-hot input word
//  out_valid  out  1          out_idx/out_err are valid
//  out_ready  in   1          consumer accepts the output word this cycle
//  out_idx    out  IDX_W      binary index of the lowest set bit
//  out_err    out  1          1 = input popcount != 1
//  err_count  out  ERR_CNT_W  number of accepted erroneous words, saturating
//  clr_err    in   1          synchronous clear of err_count
// BEHAVIOUR
//  - Reset (rst=1 at posedge) sets the following; all in-flight words are dropped:
//    - in_ready=0 during reset, 1 from the first cycle after;
//    - out_valid=0, out_idx=0, out_err=0, err_count=0.
//  - Handshake on both ports:
//    - accept when in_valid & in_ready; transfer out when out_valid & out_ready;
//    - producer holds in_onehot stable while in_valid & !in_ready.
//  - Encode (combinational, in front of the buffer):
//    - idx = index of the lowest set bit, 0 if none;
//    - err = (popcount(in_onehot) != 1).
//    - Examples: 8'b0000_0000 -> idx 0, err 1; 8'b0010_0100 -> idx 2, err 1.
//  - Buffer: 2-entry FIFO of {idx, err}, entries held in registers.
//    - in_ready = !full. It depends only on registered occupancy, never combinationally
//      on out_ready.
//    - Latency: a word accepted at edge k into an empty FIFO gives out_valid=1 in cycle
//      k+1, so one cycle of latency.
//    - Throughput is one word per cycle while out_ready=1.
//    - Occupancy 1, push and pop in the same cycle: occupancy stays 1 and the new word
//      is presented the next cycle.
//    - Occupancy 2: in_ready=0; a pop frees a slot, and in_ready=1 next cycle.
//    - Occupancy 0 and out_ready=1: no bypass; out_valid stays 0.
//    - out_idx/out_err hold their value while out_valid & !out_ready.
//    - Pointers wrap modulo 2. Words leave in order, with no loss and no duplication.
//  - err_count:
//    - increments by 1 on each accepted word with err=1, and saturates at 2^ERR_CNT_W-1;
//    - clr_err=1 with no error accept: next value 0;
//    - clr_err=1 with an error accept in the same cycle: next value 1 (the event is not lost);
//    - while saturated and no clr_err: holds at max.
//  - No explicit FSM. FIFO occupancy (0/1/2) is the only control state, and illegal
//    encodings cannot be reached.
// STRUCTURE
//  - Package one_hot_pkg holds:
//    - function popcount(N-bit);
//    - function lsb_index(N-bit) -> IDX_W;
//    - FIFO depth constant OH_FIFO_DEPTH=2;
//    - packed struct oh_word_t {idx, err}, shared with one_hot_decoder benches.
//  - Sub-module onehot_skid_fifo2 is parameterised on payload width and owns
//    occupancy, in_ready and out_valid.
//  - The top level holds the encode logic, the error counter and the instantiation.
// TESTING
//  1 Loopback through one_hot_decoder, bin_in 0..7, out_ready=1:
//    -> out_idx == bin_in one cycle after each accept, out_err=0, err_count=0.
//  2 in_onehot=8'h00, then 8'b0010_0100:
//    -> (idx 0, err 1), then (idx 2, err 1); err_count=2.
//  3 Backpressure: out_ready=0, offer 8'h01, 8'h02, 8'h04 back to back:
//    -> in_ready falls after 2 accepts, 8'h04 is held;
//    -> then out_ready=1 drains idx 0, 1, 2 in order.
//  4 ERR_CNT_W=2, accept 5 error words:
//    -> err_count 1, 2, 3, 3, 3;
//    -> clr_err together with an error accept -> 1.
//  5 rst asserted with 2 words buffered:
//    -> the next cycle has out_valid=0, err_count=0, in_ready=0;
//    -> the cycle after has in_ready=1, and no stale word appears.
//  6 Random valid/ready (10k cycles) vs a scoreboard:
//    -> order and values match, no drops, in_ready never 1 when full.

Source files
------------

// File: rtl/one_hot_pkg.sv
// Shared types and helpers for the one-hot stream encoder.
package one_hot_pkg;

  // Widest one-hot word the helper functions accept
  localparam int unsigned OH_MAX_N     = 64;
  localparam int unsigned OH_MAX_IDX_W = 6;
  localparam int unsigned OH_CNT_W     = 7;

  // Skid FIFO depth
  localparam int unsigned OH_FIFO_DEPTH = 2;

  // Default configuration, shared with one_hot_decoder benches
  localparam int unsigned OH_N     = 8;
  localparam int unsigned OH_IDX_W = 3;

  typedef struct packed {
    logic [OH_IDX_W-1:0] idx;
    logic                err;
  } oh_word_t;

  // Number of set bits in a (zero-extended) word
  function automatic logic [OH_CNT_W-1:0] popcount(input logic [OH_MAX_N-1:0] v);
    logic [OH_CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < int'(OH_MAX_N); i++) begin
      sum = sum + OH_CNT_W'(v[i]);
    end
    return sum;
  endfunction

  // Index of the lowest set bit, 0 when no bit is set
  function automatic logic [OH_MAX_IDX_W-1:0] lsb_index(input logic [OH_MAX_N-1:0] v);
    logic [OH_MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(OH_MAX_N) - 1; i >= 0; i--) begin
      if (v[i]) idx = OH_MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_skid_fifo2.sv
// Two-entry registered FIFO; in_ready depends only on registered occupancy.
module onehot_skid_fifo2
  import one_hot_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam int unsigned CNT_W = $clog2(OH_FIFO_DEPTH + 1);

  logic [W-1:0]     mem_q [OH_FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             push;
  logic             pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Next occupancy from the handshakes on both sides
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage, pointers and registered flow-control flags
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < int'(OH_FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q     <= count_d;
      in_ready_q  <= (count_d != CNT_W'(OH_FIFO_DEPTH));
      out_valid_q <= (count_d != '0);
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/one_hot_stream_encoder.sv
// Streaming one-hot to binary encoder with per-word validity flag and error counter.
module one_hot_stream_encoder
  import one_hot_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned IDX_W     = $clog2(N),
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_onehot,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err
);

  localparam int unsigned PAY_W = IDX_W + 1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [IDX_W-1:0]     enc_idx;
  logic                 enc_err;
  logic [PAY_W-1:0]     enc_word;
  logic [PAY_W-1:0]     fifo_word;
  logic                 err_accept;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  // Encode the incoming word ahead of the buffer
  always_comb begin
    enc_idx = IDX_W'(lsb_index(OH_MAX_N'(in_onehot)));
    enc_err = (popcount(OH_MAX_N'(in_onehot)) != OH_CNT_W'(1));
  end

  assign enc_word = {enc_idx, enc_err};

  onehot_skid_fifo2 #(
    .W(PAY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (enc_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (fifo_word)
  );

  assign out_idx = fifo_word[PAY_W-1:1];
  assign out_err = fifo_word[0];

  assign err_accept = in_valid & in_ready & enc_err;

  // Saturating error count; a clear never swallows a same-cycle error
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = ERR_CNT_W'(err_accept);
    end else if (err_accept && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_one_hot_stream_encoder.sv
// Self-checking bench for one_hot_stream_encoder.
module tb_one_hot_stream_encoder;
  import one_hot_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_onehot = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_idx;
  logic       out_err;
  logic [7:0] err_count;
  logic       clr_err = 1'b0;

  logic       in_valid2 = 1'b0;
  logic       in_ready2;
  logic [7:0] in_onehot2 = '0;
  logic       out_valid2;
  logic       out_ready2 = 1'b1;
  logic [2:0] out_idx2;
  logic       out_err2;
  logic [1:0] err_count2;
  logic       clr_err2 = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  oh_word_t m_q[$];
  int       m_cnt = 0;
  bit       m_in_ready = 1'b0;

  always #5 clk = ~clk;

  one_hot_stream_encoder #(.N(8), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_onehot(in_onehot), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_err(out_err), .err_count(err_count), .clr_err(clr_err)
  );

  one_hot_stream_encoder #(.N(8), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_onehot(in_onehot2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_idx(out_idx2), .out_err(out_err2), .err_count(err_count2), .clr_err(clr_err2)
  );

  function automatic oh_word_t ref_word(input logic [7:0] w);
    oh_word_t r;
    r.idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w[i]) begin
        r.idx = 3'(i);
        break;
      end
    end
    r.err = ($countones(w) != 1);
    return r;
  endfunction

  // Advance one clock and update the model from the inputs present at the edge
  task automatic tick();
    bit       push, pop, eacc;
    oh_word_t w;
    push = !rst && in_valid && m_in_ready;
    pop  = !rst && (m_q.size() != 0) && out_ready;
    w    = ref_word(in_onehot);
    eacc = push && w.err;
    @(posedge clk);
    #1;
    if (rst) begin
      m_q.delete();
      m_cnt = 0;
      m_in_ready = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(w);
      if (clr_err) m_cnt = eacc ? 1 : 0;
      else if (eacc && m_cnt < 255) m_cnt = m_cnt + 1;
      m_in_ready = (m_q.size() < 2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++;
    if (out_idx !== 3'd0 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_word: got idx %0d err %b expected idx 0 err 0", out_idx, out_err);
    end
    n_tests++;
    if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    rst = 1'b0;
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_loopback();
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      in_valid  = 1'b1;
      in_onehot = 8'(1) << b;
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_idx !== 3'(b) || out_err !== 1'b0) begin
        n_fail++;
        $display("FAIL loopback_%0d: got valid %b idx %0d err %b expected valid 1 idx %0d err 0",
                 b, out_valid, out_idx, out_err, b);
      end
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL loopback_ready_%0d: got %b expected 1", b, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL loopback_drain: got valid %b expected 0", out_valid); end
    n_tests++;
    if (err_count !== 8'd0) begin n_fail++; $display("FAIL loopback_err_count: got %0d expected 0", err_count); end
  endtask

  task automatic test_errors();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_onehot = 8'h00;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_err !== 1'b1) begin
      n_fail++; $display("FAIL err_zero: got valid %b idx %0d err %b expected valid 1 idx 0 err 1", out_valid, out_idx, out_err);
    end
    in_onehot = 8'b0010_0100;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd2 || out_err !== 1'b1) begin
      n_fail++; $display("FAIL err_multi: got valid %b idx %0d err %b expected valid 1 idx 2 err 1", out_valid, out_idx, out_err);
    end
    n_tests++;
    if (err_count !== 8'd2) begin n_fail++; $display("FAIL err_count_two: got %0d expected 2", err_count); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_onehot = 8'h01;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_first: got valid %b idx %0d ready %b expected 1 0 1", out_valid, out_idx, in_ready);
    end
    in_onehot = 8'h02;
    tick();
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got ready %b expected 0", in_ready); end
    in_onehot = 8'h04;
    tick();
    n_tests++;
    if (in_ready !== 1'b0 || out_idx !== 3'd0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: got ready %b idx %0d valid %b expected 0 0 1", in_ready, out_idx, out_valid);
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (out_idx !== 3'd1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain1: got idx %0d ready %b expected 1 1", out_idx, in_ready);
    end
    tick();
    n_tests++;
    if (out_idx !== 3'd2 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain2: got idx %0d valid %b expected 2 1", out_idx, out_valid);
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got valid %b expected 0", out_valid); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    in_valid2  = 1'b1;
    in_onehot2 = 8'h00;
    out_ready2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_cnt = (k > 3) ? 3 : k;
      n_tests++;
      if (err_count2 !== 2'(exp_cnt)) begin
        n_fail++; $display("FAIL sat_count_%0d: got %0d expected %0d", k, err_count2, exp_cnt);
      end
    end
    clr_err2 = 1'b1;
    tick();
    n_tests++;
    if (err_count2 !== 2'd1) begin n_fail++; $display("FAIL sat_clr_with_err: got %0d expected 1", err_count2); end
    in_valid2 = 1'b0;
    tick();
    n_tests++;
    if (err_count2 !== 2'd0) begin n_fail++; $display("FAIL sat_clr_only: got %0d expected 0", err_count2); end
    clr_err2 = 1'b0;
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_onehot = 8'h00;
    tick();
    in_onehot = 8'h80;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_pre_full: got valid %b ready %b expected 1 0", out_valid, in_ready);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_flush: got valid %b cnt %0d ready %b expected 0 0 0", out_valid, err_count, in_ready);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_after: got ready %b valid %b expected 1 0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale_%0d: got valid %b expected 0", k, out_valid); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      n_tests++;
      if (out_valid !== (m_q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_valid cyc %0d: got %b expected %b", c, out_valid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        n_tests++;
        if (out_idx !== m_q[0].idx || out_err !== m_q[0].err) begin
          n_fail++; $display("FAIL rnd_word cyc %0d: got idx %0d err %b expected idx %0d err %b",
                             c, out_idx, out_err, m_q[0].idx, m_q[0].err);
        end
      end
      n_tests++;
      if (in_ready !== m_in_ready) begin
        n_fail++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", c, in_ready, m_in_ready);
      end
      n_tests++;
      if (in_ready === 1'b1 && m_q.size() == 2) begin
        n_fail++; $display("FAIL rnd_ready_full cyc %0d: got ready 1 with 2 words buffered, expected 0", c);
      end
      n_tests++;
      if (err_count !== 8'(m_cnt)) begin
        n_fail++; $display("FAIL rnd_err_count cyc %0d: got %0d expected %0d", c, err_count, m_cnt);
      end
      // A stalled word stays on the bus unchanged
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) in_onehot = 8'(1) << $urandom_range(0, 7);
        else in_onehot = 8'($urandom());
      end
      out_ready = ($urandom_range(0, 2) != 0);
      clr_err   = ($urandom_range(0, 31) == 0);
      tick();
    end
    in_valid = 1'b0;
    clr_err  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_errors();
    test_backpressure();
    test_saturation();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
